// File: rtl/sram_buffer_pkg.sv
// Shared widths, FSM state encoding and helpers for the SRAM staging buffer.
// Imported by the top level and by the address pointer sub-module.
package sram_buffer_pkg;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 64;
    localparam int WEIGHT_WORDS = 8;
    localparam int NUM_IN_W     = 7;

    // Bit positions inside the pending-request vector
    localparam int PEND_WT  = 0;
    localparam int PEND_IN  = 1;
    localparam int PEND_OUT = 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_WAIT    = 3'd2,
        RD_DELIVER = 3'd3,
        WR_ISSUE   = 3'd4,
        WR_WAIT    = 3'd5,
        WR_DONE    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEL_WT  = 2'd0,
        SEL_IN  = 2'd1,
        SEL_OUT = 2'd2
    } sel_e;

    // Last address of a region of `words` entries; a zero-sized region still holds one word.
    function automatic logic [ADDR_W-1:0] region_last(input logic [ADDR_W-1:0] base,
                                                      input logic [NUM_IN_W-1:0] words);
        logic [ADDR_W-1:0] span;
        span = (words == '0) ? ADDR_W'(1) : ADDR_W'(words);
        return base + span - ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sram_buffer_addr_ptr.sv
// Region address pointer: loads its base, steps by one and, when wrapping is
// enabled, returns to the base after reaching the region's last address.
module addr_ptr
    import sram_buffer_pkg::*;
#(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = base_i;
        end else if (inc_i) begin
            if (WRAP_EN && (ptr_q == limit_i)) begin
                ptr_d = base_i;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_buffer.sv
// Single-port SRAM front end: arbitrates weight/input reads and output writes,
// one transaction at a time, with at most one pending request per type.
module sram_buffer
    import sram_buffer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                get_weights,
    input  logic                get_inputs,
    input  logic                get_out,
    input  logic [ADDR_W-1:0]   weight_base,
    input  logic [ADDR_W-1:0]   input_base,
    input  logic [ADDR_W-1:0]   output_base,
    input  logic [NUM_IN_W-1:0] num_inputs,
    input  logic [DATA_W-1:0]   out_data,
    output logic [DATA_W-1:0]   data,
    output logic                data_ready,
    output logic                out_done,
    output logic                busy,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_ren,
    output logic                sram_wen,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_rvalid,
    input  logic                sram_wack
);

    state_e            state_q, state_d;
    sel_e              sel_q, sel_d;
    logic [2:0]        pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] out_hold_q, out_hold_d;

    logic [2:0]        req;
    logic              wt_inc, in_inc, out_inc;
    logic [ADDR_W-1:0] wt_ptr, in_ptr, out_ptr;
    logic [ADDR_W-1:0] wt_limit, in_limit;

    assign req      = {get_out, get_inputs, get_weights};
    assign wt_limit = region_last(weight_base, NUM_IN_W'(WEIGHT_WORDS));
    assign in_limit = region_last(input_base, num_inputs);

    addr_ptr #(.WRAP_EN(1'b1)) u_wt_ptr (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (clear),
        .inc_i  (wt_inc),
        .base_i (weight_base),
        .limit_i(wt_limit),
        .ptr_o  (wt_ptr)
    );

    addr_ptr #(.WRAP_EN(1'b1)) u_in_ptr (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (clear),
        .inc_i  (in_inc),
        .base_i (input_base),
        .limit_i(in_limit),
        .ptr_o  (in_ptr)
    );

    // The output region is a plain log that only rolls over at the top of the address space.
    addr_ptr #(.WRAP_EN(1'b0)) u_out_ptr (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (clear),
        .inc_i  (out_inc),
        .base_i (output_base),
        .limit_i(output_base),
        .ptr_o  (out_ptr)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pend_d     = pend_q | req;
        addr_d     = addr_q;
        data_d     = data_q;
        wdata_d    = wdata_q;
        out_hold_d = out_hold_q;
        wt_inc     = 1'b0;
        in_inc     = 1'b0;
        out_inc    = 1'b0;

        // The write payload belongs to the request that first raised the pending bit.
        if (get_out && !pend_q[PEND_OUT]) begin
            out_hold_d = out_data;
        end

        case (state_q)
            IDLE: begin
                if (pend_q[PEND_WT]) begin
                    pend_d[PEND_WT] = 1'b0;
                    sel_d           = SEL_WT;
                    addr_d          = wt_ptr;
                    state_d         = RD_ISSUE;
                end else if (pend_q[PEND_IN]) begin
                    pend_d[PEND_IN] = 1'b0;
                    sel_d           = SEL_IN;
                    addr_d          = in_ptr;
                    state_d         = RD_ISSUE;
                end else if (pend_q[PEND_OUT]) begin
                    pend_d[PEND_OUT] = 1'b0;
                    sel_d            = SEL_OUT;
                    addr_d           = out_ptr;
                    wdata_d          = out_hold_q;
                    state_d          = WR_ISSUE;
                end
            end
            RD_ISSUE:   state_d = RD_WAIT;
            RD_WAIT: begin
                if (sram_rvalid) begin
                    data_d  = sram_rdata;
                    state_d = RD_DELIVER;
                end
            end
            RD_DELIVER: begin
                wt_inc  = (sel_q == SEL_WT);
                in_inc  = (sel_q == SEL_IN);
                state_d = IDLE;
            end
            WR_ISSUE:   state_d = WR_WAIT;
            WR_WAIT: begin
                if (sram_wack) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                out_inc = 1'b1;
                state_d = IDLE;
            end
            default:    state_d = IDLE;
        endcase

        // Start of a new inference abandons whatever is queued or in flight.
        if (clear) begin
            state_d = IDLE;
            pend_d  = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= SEL_WT;
            pend_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wdata_q    <= '0;
            out_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wdata_q    <= wdata_d;
            out_hold_q <= out_hold_d;
        end
    end

    assign sram_ren   = (state_q == RD_ISSUE);
    assign sram_wen   = (state_q == WR_ISSUE);
    assign sram_addr  = (sram_ren || sram_wen) ? addr_q : '0;
    assign sram_wdata = sram_wen ? wdata_q : '0;
    assign data       = data_q;
    assign data_ready = (state_q == RD_DELIVER);
    assign out_done   = (state_q == WR_DONE);
    assign busy       = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_sram_buffer.sv
// Directed bench for sram_buffer: the bench plays the SRAM and checks fetches,
// wrap-around, priority, writes, clear-abort and reset-abort against fixed values.
module tb_sram_buffer;

    logic        clk = 1'b0;
    logic        rst, clear, get_weights, get_inputs, get_out;
    logic [9:0]  weight_base, input_base, output_base;
    logic [6:0]  num_inputs;
    logic [63:0] out_data, data, sram_wdata, sram_rdata;
    logic        data_ready, out_done, busy, sram_ren, sram_wen, sram_rvalid, sram_wack;
    logic [9:0]  sram_addr;

    int checks = 0;
    int failures = 0;
    int readyCount = 0;
    int doneCount = 0;

    sram_buffer dut (
        .clk(clk), .rst(rst), .clear(clear),
        .get_weights(get_weights), .get_inputs(get_inputs), .get_out(get_out),
        .weight_base(weight_base), .input_base(input_base), .output_base(output_base),
        .num_inputs(num_inputs), .out_data(out_data),
        .data(data), .data_ready(data_ready), .out_done(out_done), .busy(busy),
        .sram_addr(sram_addr), .sram_ren(sram_ren), .sram_wen(sram_wen),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_rvalid(sram_rvalid), .sram_wack(sram_wack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_ready) readyCount++;
        if (out_done) doneCount++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic i, input logic o);
        get_weights = w;
        get_inputs  = i;
        get_out     = o;
        tick();
        get_weights = 1'b0;
        get_inputs  = 1'b0;
        get_out     = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic waitStrobe(input string tag, input bit wantWrite);
        int n = 0;
        while (!(wantWrite ? sram_wen : sram_ren) && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_strobe"}, 64'(wantWrite ? sram_wen : sram_ren), 64'd1);
    endtask

    // Play one SRAM read: rvalid comes `latency` cycles after the ren cycle.
    task automatic serveRead(input string tag, input logic [9:0] expAddr,
                             input logic [63:0] rd, input int latency);
        waitStrobe(tag, 1'b0);
        checkOutput({tag, "_addr"}, 64'(sram_addr), 64'(expAddr));
        tick();
        checkOutput({tag, "_ren_once"}, 64'(sram_ren), 64'd0);
        repeat (latency - 1) tick();
        sram_rvalid = 1'b1;
        sram_rdata  = rd;
        tick();
        sram_rvalid = 1'b0;
        sram_rdata  = ~rd;
        checkOutput({tag, "_ready"}, 64'(data_ready), 64'd1);
        checkOutput({tag, "_data"}, data, rd);
        tick();
        checkOutput({tag, "_ready_once"}, 64'(data_ready), 64'd0);
        checkOutput({tag, "_hold"}, data, rd);
    endtask

    task automatic serveWrite(input string tag, input logic [9:0] expAddr,
                              input logic [63:0] expData, input int wackDelay);
        waitStrobe(tag, 1'b1);
        checkOutput({tag, "_addr"}, 64'(sram_addr), 64'(expAddr));
        checkOutput({tag, "_wdata"}, sram_wdata, expData);
        tick();
        checkOutput({tag, "_wen_once"}, 64'(sram_wen), 64'd0);
        repeat (wackDelay - 1) tick();
        checkOutput({tag, "_no_early_done"}, 64'(out_done), 64'd0);
        sram_wack = 1'b1;
        tick();
        sram_wack = 1'b0;
        checkOutput({tag, "_done"}, 64'(out_done), 64'd1);
        tick();
        checkOutput({tag, "_done_once"}, 64'(out_done), 64'd0);
    endtask

    initial begin
        int rc;
        logic [63:0] rd;
        rst = 1'b1; clear = 1'b0;
        get_weights = 1'b0; get_inputs = 1'b0; get_out = 1'b0;
        weight_base = 10'h040; input_base = 10'h100; output_base = 10'h200;
        num_inputs = 7'd4; out_data = '0;
        sram_rdata = '0; sram_rvalid = 1'b0; sram_wack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_data", data, 64'd0);
        checkOutput("rst_ready", 64'(data_ready), 64'd0);
        checkOutput("rst_done", 64'(out_done), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ren_wen", 64'({sram_ren, sram_wen}), 64'd0);
        checkOutput("rst_addr", 64'(sram_addr), 64'd0);
        checkOutput("rst_wdata", sram_wdata, 64'd0);

        // Pointers come out of reset at zero, not at the bases
        applyStimulus(1'b1, 1'b0, 1'b0);
        serveRead("rst_ptr", 10'h000, 64'h1111_2222_3333_4444, 2);

        doClear();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pend_busy", 64'(busy), 64'd1);
        serveRead("wfetch", 10'h040, 64'hAAAA_0000_BBBB_0000, 8);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        serveRead("wptr_adv", 10'h041, 64'h5555_6666_7777_8888, 1);

        doClear();
        for (int i = 0; i < 9; i++) begin
            rd = 64'hC0DE_0000_0000_0000 | 64'(i);
            applyStimulus(1'b1, 1'b0, 1'b0);
            serveRead($sformatf("wwrap%0d", i), 10'h040 + 10'(i % 8), rd, 1 + (i % 3));
        end

        doClear();
        rc = readyCount;
        applyStimulus(1'b1, 1'b1, 1'b0);
        serveRead("prio_wt", 10'h040, 64'hFEED_0000_0000_0001, 3);
        serveRead("prio_in", 10'h100, 64'hFEED_0000_0000_0002, 2);
        checkOutput("prio_count", 64'(readyCount - rc), 64'd2);

        // Duplicate weight pulses while pending collapse to a single fetch
        rc = readyCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        serveRead("dup_wt", 10'h041, 64'hD0D0_0000_0000_0001, 2);
        repeat (15) tick();
        checkOutput("dup_count", 64'(readyCount - rc), 64'd1);
        checkOutput("dup_ren_idle", 64'(sram_ren), 64'd0);

        num_inputs = 7'd2;
        doClear();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            serveRead($sformatf("iwrap%0d", i), 10'h100 + 10'(i % 2), 64'hB0B0_0000_0000_0000 | 64'(i), 2);
        end
        num_inputs = 7'd0;
        doClear();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            serveRead($sformatf("izero%0d", i), 10'h100, 64'hE0E0_0000_0000_0000 | 64'(i), 1);
        end
        num_inputs = 7'd4;

        doClear();
        out_data = 64'h0123_4567_89AB_CDEF;
        applyStimulus(1'b0, 1'b0, 1'b1);
        out_data = 64'hDEAD_BEEF_DEAD_BEEF;
        serveWrite("wr0", 10'h200, 64'h0123_4567_89AB_CDEF, 3);
        out_data = 64'h0F0F_0F0F_1234_5678;
        applyStimulus(1'b0, 1'b0, 1'b1);
        out_data = '0;
        serveWrite("wr1", 10'h201, 64'h0F0F_0F0F_1234_5678, 1);

        // Advance both read pointers, then abort a read mid-flight with clear
        applyStimulus(1'b1, 1'b1, 1'b0);
        serveRead("pre_wt", 10'h040, 64'h0000_0000_0000_00A1, 1);
        serveRead("pre_in", 10'h100, 64'h0000_0000_0000_00A2, 1);
        rc = readyCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitStrobe("abort", 1'b0);
        checkOutput("abort_addr", 64'(sram_addr), 64'h041);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_ready", 64'(data_ready), 64'd0);
        sram_rvalid = 1'b1;
        sram_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        sram_rvalid = 1'b0;
        repeat (3) tick();
        checkOutput("abort_data", data, 64'h0000_0000_0000_00A2);
        checkOutput("abort_count", 64'(readyCount - rc), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        serveRead("abort_wt_base", 10'h040, 64'h0000_0000_0000_00B1, 1);
        serveRead("abort_in_base", 10'h100, 64'h0000_0000_0000_00B2, 1);

        // Reset while waiting on a write acknowledge
        rc = doneCount;
        out_data = 64'h7777_8888_9999_AAAA;
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitStrobe("rstwr", 1'b1);
        checkOutput("rstwr_addr", 64'(sram_addr), 64'h200);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rstwr_busy", 64'(busy), 64'd0);
        checkOutput("rstwr_ren_wen", 64'({sram_ren, sram_wen}), 64'd0);
        checkOutput("rstwr_addr0", 64'(sram_addr), 64'd0);
        checkOutput("rstwr_wdata", sram_wdata, 64'd0);
        checkOutput("rstwr_data", data, 64'd0);
        checkOutput("rstwr_flags", 64'({data_ready, out_done}), 64'd0);
        rst = 1'b0;
        sram_wack = 1'b1;
        tick();
        sram_wack = 1'b0;
        repeat (3) tick();
        checkOutput("rstwr_no_done", 64'(doneCount - rc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_buffer.md
SRAM_BUFFER -- requirements
Module: sram_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: clear  in  1  start-of-inference pulse; get_weights  in  1  controller weight-word request pulse; get_inputs  in  1  input-word request pulse; get_out  in  1  output-word write request pulse.
REQ-003 SHALL have ports: weight_base  in  10  weight region base; input_base  in  10  input region base; output_base  in  10  output region base; num_inputs  in  7  input words per inference.
REQ-004 SHALL have ports: out_data  in  64  result word to store; data  out  64  fetched word; data_ready  out  1  one-cycle data-valid strobe; out_done  out  1  one-cycle write-complete strobe; busy  out  1  transaction in progress.
REQ-005 SHALL have ports: sram_addr  out  10; sram_ren  out  1; sram_wen  out  1; sram_wdata  out  64; sram_rdata  in  64; sram_rvalid  in  1 read-data-valid; sram_wack  in  1 write acknowledge.

Function
REQ-006 SHALL use FSM states IDLE, RD_ISSUE, RD_WAIT, RD_DELIVER, WR_ISSUE, WR_WAIT, WR_DONE.
REQ-007 SHALL, in IDLE, latch a pending bit for every request pulse seen in any state and select the next pending request in priority weights > inputs > out.
REQ-008 SHALL, for a selected read, drive sram_addr = the selected pointer and sram_ren = 1 for exactly one cycle (RD_ISSUE), then wait in RD_WAIT.
REQ-009 SHALL capture sram_rdata into data on the cycle sram_rvalid = 1, then assert data_ready for exactly one cycle (RD_DELIVER) with data stable, and return to IDLE.
REQ-010 SHALL hold data unchanged from capture until the next capture.
REQ-011 SHALL, for a write, drive sram_wen = 1, sram_addr = out_ptr, sram_wdata = out_data sampled at request, for one cycle, wait for sram_wack, then pulse out_done one cycle.
REQ-012 SHALL advance the used pointer by 1 on the data_ready or out_done cycle.
REQ-013 SHALL wrap wt_ptr from weight_base+7 back to weight_base (8 weight words).
REQ-014 SHALL wrap in_ptr from input_base+num_inputs-1 back to input_base; num_inputs = 0 treated as 1.
REQ-015 SHALL let out_ptr increment without region wrap, modulo 1024.
REQ-016 SHALL assert busy in every non-IDLE state and whenever any pending bit is set.
REQ-017 SHALL record a duplicate request of a type already pending as a single request (no queueing beyond one per type).
REQ-018 SHALL, on clear, load wt_ptr/in_ptr/out_ptr from the bases and drop all pending bits; clear during a transaction aborts it and returns to IDLE next cycle without data_ready/out_done.
REQ-019 SHALL ignore sram_rvalid/sram_wack outside RD_WAIT/WR_WAIT.

Reset
REQ-020 SHALL, on rst at clk edge, set state IDLE, pending bits 0, pointers 0, data 0, and all outputs (data_ready, out_done, busy, sram_ren, sram_wen, sram_addr, sram_wdata) 0.
REQ-021 SHALL give rst priority over clear and all requests.

Structure
REQ-022 SHALL place ADDR_W=10, DATA_W=64, WEIGHT_WORDS=8 and the FSM state enum in shared package sram_buffer_pkg.
REQ-023 SHALL implement each wrapping pointer as an instance of sub-module addr_ptr (load, inc, base, limit) instantiated three times.

Verification
REQ-024 Weight fetch: weight_base=0x040, clear, get_weights, rvalid 8 cycles after ren, rdata=0xAAAA0000BBBB0000 -> sram_addr=0x040, one data_ready with that data, wt_ptr=0x041.
REQ-025 Weight wrap: 9 consecutive weight fetches -> addresses 0x040..0x047 then 0x040.
REQ-026 Priority: get_inputs and get_weights same cycle (input_base=0x100) -> read 0x040 first, then 0x100; exactly two data_ready pulses.
REQ-027 Write: output_base=0x200, out_data=0x0123456789ABCDEF, get_out, wack after 3 cycles -> sram_wen one cycle at 0x200 with that data, out_done one cycle later, next write to 0x201.
REQ-028 Abort: clear asserted in RD_WAIT -> IDLE next cycle, no data_ready, later rvalid ignored, pointers at bases.
REQ-029 Reset mid-write: rst in WR_WAIT -> all outputs 0 next cycle, busy 0, no out_done.
